// File: rtl/dl_agc_pkg.sv
// Shared constants and helpers for the downlink per-carrier gain stage.
package dl_agc_pkg;

    // Input-to-output latency of the gain pipeline, in clocks.
    localparam int unsigned AGC_LAT = 4;

    // Unity gain for an unsigned Q2.(gw-2) gain word.
    function automatic int unsigned unity(input int unsigned gw);
        return 32'd1 << (gw - 2);
    endfunction

    // Symmetric saturation limits for a dw-bit signed sample.
    function automatic longint sat_max(input int unsigned dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned dw);
        return -sat_max(dw);
    endfunction

    // Index width for n slots, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dl_tdl_agc_ramp_if.sv
// Sample stream into and out of the gain stage, with its delay-matched sidebands.
interface dl_tdl_agc_ramp_if #(
    parameter int unsigned DW = 16
);
    logic            i_fram_hd;
    logic [2*DW-1:0] i_data;
    logic            i_data_valid;
    logic            i_ant8_sel;
    logic            o_fram_hd;
    logic            o_ant8_sel;
    logic            o_data_valid;
    logic [2*DW-1:0] o_data;
    logic            o_sat;

    // Upstream side (de-framer / bench) drives samples and observes results.
    modport master (
        output i_fram_hd, i_data, i_data_valid, i_ant8_sel,
        input  o_fram_hd, o_ant8_sel, o_data_valid, o_data, o_sat
    );

    // Gain stage side.
    modport slave (
        input  i_fram_hd, i_data, i_data_valid, i_ant8_sel,
        output o_fram_hd, o_ant8_sel, o_data_valid, o_data, o_sat
    );
endinterface

// File: rtl/dl_agc_mac.sv
// One rail (I or Q): signed x unsigned multiply, round half-up, symmetric saturate.
// Covers S1 (product) and S2 (round/saturate); the output register lives in the top.
module dl_agc_mac
    import dl_agc_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned GW = 16
) (
    input  logic                 clk_245,
    input  logic                 asy_rst,
    input  logic signed [DW-1:0] data_i,
    input  logic [GW-1:0]        gain_i,
    input  logic                 mute_i,
    output logic signed [DW-1:0] res_o,
    output logic                 sat_o
);
    localparam int unsigned PW = DW + GW + 1;
    localparam logic signed [PW-1:0] RndAdd  = PW'(unity(GW) >> 1);
    localparam logic signed [PW-1:0] SatMaxP = PW'(sat_max(DW));
    localparam logic signed [PW-1:0] SatMinP = PW'(sat_min(DW));

    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_q;
    logic                 mute1_q;
    logic signed [PW-1:0] rnd_sum;
    logic signed [PW-1:0] shifted;
    logic signed [DW-1:0] res_d;
    logic                 sat_d;
    logic signed [DW-1:0] res_q;
    logic                 sat_q;

    assign data_ext = {{(GW + 1){data_i[DW-1]}}, data_i};
    assign gain_ext = {{(DW + 1){1'b0}}, gain_i};

    // S1: full-width product; max gain ~4x cannot overflow PW bits.
    always_ff @(posedge clk_245 or negedge asy_rst) begin
        if (!asy_rst) begin
            prod_q  <= '0;
            mute1_q <= 1'b0;
        end else begin
            prod_q  <= data_ext * gain_ext;
            mute1_q <= mute_i;
        end
    end

    // S2 next-state: round half-up, rescale by unity, clamp to the symmetric range.
    always_comb begin
        rnd_sum = prod_q + RndAdd;
        shifted = rnd_sum >>> (GW - 2);
        res_d   = shifted[DW-1:0];
        sat_d   = 1'b0;
        if (mute1_q) begin
            res_d = '0;
        end else if (shifted > SatMaxP) begin
            res_d = SatMaxP[DW-1:0];
            sat_d = 1'b1;
        end else if (shifted < SatMinP) begin
            res_d = SatMinP[DW-1:0];
            sat_d = 1'b1;
        end
    end

    // S2 register.
    always_ff @(posedge clk_245 or negedge asy_rst) begin
        if (!asy_rst) begin
            res_q <= '0;
            sat_q <= 1'b0;
        end else begin
            res_q <= res_d;
            sat_q <= sat_d;
        end
    end

    assign res_o = res_q;
    assign sat_o = sat_q;
endmodule

// File: rtl/dl_tdl_agc_ramp.sv
// Per-channel linear gain on TDM-interleaved I/Q with optional frame-synchronous ramping.
module dl_tdl_agc_ramp
    import dl_agc_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned GW        = 16,
    parameter int unsigned RAMP_STEP = 64
) (
    input  logic                clk_245,
    input  logic                asy_rst,
    dl_tdl_agc_ramp_if.slave    bus,
    input  logic [NCH*GW-1:0]   i_gain_tgt,
    input  logic                i_gain_upd,
    input  logic                i_ramp_en,
    input  logic                i_mute,
    output logic                o_ramp_busy
);
    localparam int unsigned SW = clog2(NCH);
    localparam logic [GW-1:0] Unity = GW'(unity(GW));
    localparam logic [GW-1:0] Step  = GW'(RAMP_STEP);

    logic [SW-1:0]      slot_q, slot_d, ch;
    logic [GW-1:0]      tgt_q [NCH];
    logic [GW-1:0]      cur_q [NCH];
    logic [GW-1:0]      cur_d [NCH];
    logic               busy_d;
    logic               hdr_step;
    logic [2*DW-1:0]    data_s0_q;
    logic [GW-1:0]      gain_s0_q;
    logic               mute_s0_q;
    logic [AGC_LAT-1:0] hd_sr_q, ant_sr_q, vld_sr_q;
    logic signed [DW-1:0] res_i, res_q;
    logic               sat_i, sat_q;
    logic [2*DW-1:0]    data_out_q;
    logic               sat_out_q;

    assign ch       = bus.i_fram_hd ? '0 : slot_q;
    assign hdr_step = bus.i_fram_hd & bus.i_data_valid;

    // Slot counter, current-gain update and busy compare.
    always_comb begin
        slot_d = slot_q;
        if (bus.i_data_valid) slot_d = (ch == SW'(NCH - 1)) ? '0 : ch + 1'b1;
        busy_d = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cur_d[k] = cur_q[k];
            if (!i_ramp_en) begin
                cur_d[k] = tgt_q[k];
            end else if (hdr_step) begin
                // Step toward the pre-update target without overshoot.
                if (cur_q[k] < tgt_q[k]) begin
                    cur_d[k] = (tgt_q[k] - cur_q[k] > Step) ? cur_q[k] + Step : tgt_q[k];
                end else if (cur_q[k] > tgt_q[k]) begin
                    cur_d[k] = (cur_q[k] - tgt_q[k] > Step) ? cur_q[k] - Step : tgt_q[k];
                end
            end
            if (cur_q[k] != tgt_q[k]) busy_d = 1'b1;
        end
    end

    // Gain control state.
    always_ff @(posedge clk_245 or negedge asy_rst) begin
        if (!asy_rst) begin
            slot_q      <= '0;
            o_ramp_busy <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                tgt_q[k] <= Unity;
                cur_q[k] <= Unity;
            end
        end else begin
            slot_q      <= slot_d;
            o_ramp_busy <= busy_d;
            for (int k = 0; k < NCH; k++) begin
                if (i_gain_upd) tgt_q[k] <= i_gain_tgt[k*GW +: GW];
                cur_q[k] <= cur_d[k];
            end
        end
    end

    // S0 capture (gain taken before any same-cycle update) and sideband delay lines.
    always_ff @(posedge clk_245 or negedge asy_rst) begin
        if (!asy_rst) begin
            data_s0_q <= '0;
            gain_s0_q <= '0;
            mute_s0_q <= 1'b0;
            hd_sr_q   <= '0;
            ant_sr_q  <= '0;
            vld_sr_q  <= '0;
        end else begin
            data_s0_q <= bus.i_data;
            gain_s0_q <= cur_q[ch];
            mute_s0_q <= i_mute;
            hd_sr_q   <= {hd_sr_q[AGC_LAT-2:0], bus.i_fram_hd};
            ant_sr_q  <= {ant_sr_q[AGC_LAT-2:0], bus.i_ant8_sel};
            vld_sr_q  <= {vld_sr_q[AGC_LAT-2:0], bus.i_data_valid};
        end
    end

    dl_agc_mac #(.DW(DW), .GW(GW)) u_mac_i (
        .clk_245 (clk_245),
        .asy_rst (asy_rst),
        .data_i  ($signed(data_s0_q[2*DW-1:DW])),
        .gain_i  (gain_s0_q),
        .mute_i  (mute_s0_q),
        .res_o   (res_i),
        .sat_o   (sat_i)
    );

    dl_agc_mac #(.DW(DW), .GW(GW)) u_mac_q (
        .clk_245 (clk_245),
        .asy_rst (asy_rst),
        .data_i  ($signed(data_s0_q[DW-1:0])),
        .gain_i  (gain_s0_q),
        .mute_i  (mute_s0_q),
        .res_o   (res_q),
        .sat_o   (sat_q)
    );

    // S3 output register: data holds on invalid slots, sat only flags valid samples.
    always_ff @(posedge clk_245 or negedge asy_rst) begin
        if (!asy_rst) begin
            data_out_q <= '0;
            sat_out_q  <= 1'b0;
        end else if (vld_sr_q[AGC_LAT-2]) begin
            data_out_q <= {res_i, res_q};
            sat_out_q  <= sat_i | sat_q;
        end else begin
            sat_out_q  <= 1'b0;
        end
    end

    assign bus.o_data       = data_out_q;
    assign bus.o_sat        = sat_out_q;
    assign bus.o_fram_hd    = hd_sr_q[AGC_LAT-1];
    assign bus.o_ant8_sel   = ant_sr_q[AGC_LAT-1];
    assign bus.o_data_valid = vld_sr_q[AGC_LAT-1];
endmodule

// File: tb/tb_dl_tdl_agc_ramp.sv
// Directed self-checking bench for dl_tdl_agc_ramp (NCH=4, DW=16, GW=16, RAMP_STEP=64).
module tb_dl_tdl_agc_ramp;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned GW  = 16;

    logic              clk_245 = 1'b0;
    logic              asy_rst = 1'b0;
    logic [NCH*GW-1:0] gain_tgt;
    logic              gain_upd;
    logic              ramp_en;
    logic              mute;
    logic              ramp_busy;
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk_245 = ~clk_245;

    dl_tdl_agc_ramp_if #(.DW(DW)) bus ();

    dl_tdl_agc_ramp #(.NCH(NCH), .DW(DW), .GW(GW), .RAMP_STEP(64)) dut (
        .clk_245     (clk_245),
        .asy_rst     (asy_rst),
        .bus         (bus),
        .i_gain_tgt  (gain_tgt),
        .i_gain_upd  (gain_upd),
        .i_ramp_en   (ramp_en),
        .i_mute      (mute),
        .o_ramp_busy (ramp_busy)
    );

    task automatic cyc();
        @(posedge clk_245);
        #1;
    endtask

    task automatic drive(input logic hd, input logic vld, input logic ant, input logic [31:0] d);
        bus.i_fram_hd    = hd;
        bus.i_data_valid = vld;
        bus.i_ant8_sel   = ant;
        bus.i_data       = d;
    endtask

    // Latch new targets with immediate apply; gains are live two edges later.
    task automatic set_gains(input logic [NCH*GW-1:0] g);
        gain_tgt = g;
        gain_upd = 1'b1;
        cyc();
        gain_upd = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        gain_tgt = {NCH{16'h4000}};
        gain_upd = 1'b0;
        ramp_en  = 1'b0;
        mute     = 1'b0;
        asy_rst  = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (bus.o_data !== 32'h0) begin
            $display("FAIL reset_data: got %h expected %h", bus.o_data, 32'h0);
            n_fail++;
        end
        n_checks++;
        if ({bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat, ramp_busy} !== 5'b0) begin
            $display("FAIL reset_flags: got %b expected %b",
                     {bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat, ramp_busy}, 5'b0);
            n_fail++;
        end
        asy_rst = 1'b1;
        cyc();
    endtask

    task automatic test_unity();
        drive(1'b1, 1'b1, 1'b1, 32'h1234F000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        cyc();
        n_checks++;
        if (bus.o_data_valid !== 1'b0) begin
            $display("FAIL unity_early_valid: got %b expected %b", bus.o_data_valid, 1'b0);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (bus.o_data !== 32'h1234F000) begin
            $display("FAIL unity_data: got %h expected %h", bus.o_data, 32'h1234F000);
            n_fail++;
        end
        n_checks++;
        if ({bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat} !== 4'b1110) begin
            $display("FAIL unity_sideband: got %b expected %b",
                     {bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat}, 4'b1110);
            n_fail++;
        end
        cyc();
        n_checks++;
        if ({bus.o_data_valid, bus.o_data} !== {1'b0, 32'h1234F000}) begin
            $display("FAIL unity_hold: got %b/%h expected 0/%h",
                     bus.o_data_valid, bus.o_data, 32'h1234F000);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        set_gains({NCH{16'h8000}});
        drive(1'b1, 1'b1, 1'b0, 32'h5000B000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(); cyc(); cyc();
        n_checks++;
        if ({bus.o_data, bus.o_sat} !== {32'h7FFF8001, 1'b1}) begin
            $display("FAIL sat_data: got %h/%b expected %h/1", bus.o_data, bus.o_sat, 32'h7FFF8001);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (bus.o_sat !== 1'b0) begin
            $display("FAIL sat_idle_clear: got %b expected %b", bus.o_sat, 1'b0);
            n_fail++;
        end
        mute = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h5000B000);
        cyc();
        mute = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(); cyc(); cyc();
        n_checks++;
        if ({bus.o_data_valid, bus.o_data, bus.o_sat} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL mute: got %b/%h/%b expected 1/%h/0",
                     bus.o_data_valid, bus.o_data, bus.o_sat, 32'h0);
            n_fail++;
        end
    endtask

    task automatic test_rounding();
        set_gains({NCH{16'h2000}});
        drive(1'b1, 1'b1, 1'b0, {16'h0003, 16'hFFFD});
        cyc();
        drive(1'b0, 1'b1, 1'b0, {16'h0001, 16'hFFFF});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(); cyc();
        n_checks++;
        if (bus.o_data !== {16'h0002, 16'hFFFF}) begin
            $display("FAIL round_3: got %h expected %h", bus.o_data, {16'h0002, 16'hFFFF});
            n_fail++;
        end
        cyc();
        n_checks++;
        if (bus.o_data !== {16'h0001, 16'h0000}) begin
            $display("FAIL round_1: got %h expected %h", bus.o_data, {16'h0001, 16'h0000});
            n_fail++;
        end
    endtask

    task automatic test_per_channel();
        logic        vld [11];
        logic [31:0] exp_d [11];
        int          n;
        vld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_d = '{32'h40004000, 32'h20002000, 32'h0, 32'h10001000, 32'h00000000,
                  32'h40004000, 32'h0, 32'h0, 32'h20002000, 32'h10001000, 32'h00000000};
        set_gains({16'd0, 16'd4096, 16'd8192, 16'd16384});
        for (int j = 0; j < 14; j++) begin
            if (j < 11) drive((j == 0), vld[j], 1'b0, 32'h40004000);
            else drive(1'b0, 1'b0, 1'b0, 32'h0);
            cyc();
            if (j >= 3) begin
                n = j - 3;
                n_checks++;
                if (bus.o_data_valid !== vld[n]) begin
                    $display("FAIL chan_valid[%0d]: got %b expected %b", n, bus.o_data_valid, vld[n]);
                    n_fail++;
                end
                if (vld[n]) begin
                    n_checks++;
                    if (bus.o_data !== exp_d[n]) begin
                        $display("FAIL chan_data[%0d]: got %h expected %h", n, bus.o_data, exp_d[n]);
                        n_fail++;
                    end
                end
            end
        end
    endtask

    task automatic test_ramp();
        logic [31:0] exp_d [5];
        exp_d = '{32'h40004000, 32'h40404040, 32'h40804080, 32'h40C040C0, 32'h40C840C8};
        set_gains({NCH{16'h4000}});
        ramp_en  = 1'b1;
        gain_tgt = {16'h4000, 16'h4000, 16'h4000, 16'd16584};
        gain_upd = 1'b1;
        cyc();
        gain_upd = 1'b0;
        cyc();
        n_checks++;
        if (ramp_busy !== 1'b1) begin
            $display("FAIL ramp_busy_rise: got %b expected %b", ramp_busy, 1'b1);
            n_fail++;
        end
        for (int j = 0; j < 8; j++) begin
            if (j < 5) drive(1'b1, 1'b1, 1'b0, 32'h40004000);
            else drive(1'b0, 1'b0, 1'b0, 32'h0);
            cyc();
            if (j >= 3) begin
                n_checks++;
                if (bus.o_data !== exp_d[j-3]) begin
                    $display("FAIL ramp_hdr%0d: got %h expected %h", j - 2, bus.o_data, exp_d[j-3]);
                    n_fail++;
                end
            end
            if (j == 3 || j == 4) begin
                n_checks++;
                if (ramp_busy !== (j == 3)) begin
                    $display("FAIL ramp_busy_hdr%0d: got %b expected %b", j + 1, ramp_busy, (j == 3));
                    n_fail++;
                end
            end
        end
        // Immediate mode: new target is live for the sample right after cur updates.
        ramp_en  = 1'b0;
        gain_tgt = {16'h4000, 16'h4000, 16'h4000, 16'd12000};
        gain_upd = 1'b1;
        cyc();
        gain_upd = 1'b0;
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h40004000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(); cyc(); cyc();
        n_checks++;
        if (bus.o_data !== 32'h2EE02EE0) begin
            $display("FAIL ramp_off_apply: got %h expected %h", bus.o_data, 32'h2EE02EE0);
            n_fail++;
        end
        n_checks++;
        if (ramp_busy !== 1'b0) begin
            $display("FAIL ramp_off_busy: got %b expected %b", ramp_busy, 1'b0);
            n_fail++;
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b1, 1'b1, 32'h40004000);
        cyc();
        drive(1'b0, 1'b1, 1'b1, 32'h40004000);
        cyc(); cyc(); cyc();
        n_checks++;
        if ({bus.o_data_valid, bus.o_data} !== {1'b1, 32'h2EE02EE0}) begin
            $display("FAIL midrst_pre: got %b/%h expected 1/%h",
                     bus.o_data_valid, bus.o_data, 32'h2EE02EE0);
            n_fail++;
        end
        #2;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        asy_rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_data, bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat} !== 36'h0) begin
            $display("FAIL midrst_async: got %h/%b%b%b%b expected all zero", bus.o_data,
                     bus.o_data_valid, bus.o_fram_hd, bus.o_ant8_sel, bus.o_sat);
            n_fail++;
        end
        cyc(); cyc();
        asy_rst = 1'b1;
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h1234F000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(); cyc();
        n_checks++;
        if (bus.o_data_valid !== 1'b0) begin
            $display("FAIL midrst_flush: got %b expected %b", bus.o_data_valid, 1'b0);
            n_fail++;
        end
        cyc();
        n_checks++;
        if ({bus.o_data_valid, bus.o_data} !== {1'b1, 32'h1234F000}) begin
            $display("FAIL midrst_unity: got %b/%h expected 1/%h",
                     bus.o_data_valid, bus.o_data, 32'h1234F000);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_rounding();
        test_per_channel();
        test_ramp();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
